// File: rtl/led_display_arbiter.sv
// Round-robin arbiter that lends the LED bar to one pattern generator per hold window.
// Define LED_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module led_display_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LED_W      = 16,
  parameter int unsigned HOLD_TICKS = 6250000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LED_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [LED_W-1:0]         o_leds,
  output logic                     o_busy
);

  localparam int unsigned CNT_W = $clog2(HOLD_TICKS + 1);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   search_base;
  logic [IDX_W-1:0]   win;
  logic               win_valid;
  logic [IDX_W-1:0]   ptr_after;
  int                 k;

`ifdef LED_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  assign search_base = rr_ptr;
`endif

  assign ptr_after = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  // Walk downward so the requester closest to search_base is the last (winning) match.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    k         = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      k = (int'(search_base) + i) % int'(NUM_REQ);
      if (i_req[k]) begin
        win       = IDX_W'(k);
        win_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      count   <= '0;
      o_grant <= '0;
      o_done  <= '0;
      o_leds  <= '0;
      o_busy  <= 1'b0;
    end else begin
      o_done <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state   <= HOLD;
            owner   <= win;
            count   <= '0;
            o_grant <= NUM_REQ'(1) << win;
            o_leds  <= i_req_data[int'(win)*LED_W +: LED_W];
            o_busy  <= 1'b1;
          end
        end
        HOLD: begin
          o_leds <= i_req_data[int'(owner)*LED_W +: LED_W];
          // Abort takes precedence over a normal end in the same cycle.
          if (!i_req[owner] || (count == CNT_W'(HOLD_TICKS - 1))) begin
            state   <= IDLE;
            count   <= '0;
            o_grant <= '0;
            o_busy  <= 1'b0;
            if (i_req[owner]) begin
              o_done <= NUM_REQ'(1) << owner;
            end
`ifdef LED_ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`else
            rr_ptr <= ptr_after;
`endif
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench for led_display_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a window-level behavioural model.
module tb_led_display_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;
  localparam int unsigned H = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [W-1:0]   leds;
  logic           busy;

  int tests = 0;
  int fails = 0;

  // Model: owner of the bar (-1 = none), grant cycles shown so far, search pointer.
  int           m_owner = -1;
  int           m_age   = 0;
  int           m_ptr   = 0;
  logic [W-1:0] m_leds  = '0;
  logic [N-1:0] m_done  = '0;

  always #5 clk = ~clk;

  led_display_arbiter #(.NUM_REQ(N), .LED_W(W), .HOLD_TICKS(H)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_req_data (data),
    .o_grant    (grant),
    .o_done     (done),
    .o_leds     (leds),
    .o_busy     (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    int start;
`ifdef LED_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    m_done = '0;
    if (rst) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_leds = '0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < int'(N); i++) begin
        int c;
        c = (start + i) % int'(N);
        if (req[c]) begin
          m_owner = c;
          m_age   = 1;
          m_leds  = data[c*W +: W];
          break;
        end
      end
    end else begin
      m_leds = data[m_owner*W +: W];
      if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % int'(N);
        m_owner = -1;
      end else if (m_age == int'(H)) begin
        m_done[m_owner] = 1'b1;
        m_ptr   = (m_owner + 1) % int'(N);
        m_owner = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  // One clock: update model, let the DUT clock, compare on the falling edge.
  task automatic tick();
    logic [N-1:0] exp_g;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_g = '0;
    if (m_owner >= 0) exp_g[m_owner] = 1'b1;
    check("grant", 64'(grant), 64'(exp_g));
    check("done",  64'(done),  64'(m_done));
    check("leds",  64'(leds),  64'(m_leds));
    check("busy",  64'(busy),  64'(m_owner >= 0));
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int order[$];
    int exp_order[5];
    logic [N-1:0] prev;

    rst  = 1'b1;
    req  = '1;
    data = {$urandom, $urandom};
    @(negedge clk);

    // Reset with all requests high.
    tick(); tick();
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_done",  64'(done),  64'h0);
    check("rst_leds",  64'(leds),  64'h0);
    check("rst_busy",  64'(busy),  64'h0);
    rst = 1'b0;
    tick();
    check("first_grant", 64'(grant), 64'h1);

    // All requesters held: collect grant order.
    order.push_back(0);
    prev = grant;
    for (int i = 0; i < 22; i++) begin
      data = {$urandom, $urandom};
      tick();
      if (grant != '0 && prev == '0) order.push_back(onehot_idx(grant));
      prev = grant;
    end
`ifdef LED_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    check("order_len", 64'(order.size() >= 5), 64'h1);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check($sformatf("order%0d", i), 64'(order[i]), 64'(exp_order[i]));

    // Single request from req1.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0010;
    data = '0; data[W +: W] = 16'h00FF;
    tick();
    check("single_grant", 64'(grant), 64'h2);
    check("single_leds",  64'(leds),  64'h00FF);
    tick(); tick(); tick();
    check("single_grant4", 64'(grant), 64'h2);
    tick();
    check("single_end_grant", 64'(grant), 64'h0);
    check("single_done",      64'(done),  64'h2);
    tick();
    check("single_regrant", 64'(grant), 64'h2);
    check("single_done_off", 64'(done), 64'h0);

    // Abort: req2 drops during its second grant cycle.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0100;
    tick();
    check("abort_g1", 64'(grant), 64'h4);
    tick();
    req = 4'b1011;
    tick();
    check("abort_grant", 64'(grant), 64'h0);
    check("abort_done",  64'(done),  64'h0);
    tick();
`ifdef LED_ARB_FIXED_PRIO_EN
    check("abort_next", 64'(grant), 64'h1);
`else
    check("abort_next", 64'(grant), 64'h8);
`endif

    // Live data follow during hold.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0001;
    data = '0; data[0 +: W] = 16'h00FF;
    tick();
    check("live_a", 64'(leds), 64'h00FF);
    data[0 +: W] = 16'hFF00;
    tick();
    check("live_b", 64'(leds), 64'hFF00);

    // Reset in grant cycle 3.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0001; data[0 +: W] = 16'hA5A5;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_grant", 64'(grant), 64'h0);
    check("midrst_leds",  64'(leds),  64'h0);
    check("midrst_done",  64'(done),  64'h0);
    rst = 1'b0;

    // Randomized traffic; owner usually keeps its request to reach normal ends.
    for (int i = 0; i < 800; i++) begin
      req  = N'($urandom);
      if (m_owner >= 0 && ($urandom_range(0, 7) != 0)) req[m_owner] = 1'b1;
      data = {$urandom, $urandom};
      rst  = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
